// File: rtl/fpadd_result_tx_if.sv
// Result-side bundle between the adder datapath, the transmitter and the downstream consumer.
// Latency: none; this only carries wires.
// Backpressure: in_ready and m_ready carry the stall information in each direction.
interface fpadd_result_tx_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic                     m_valid;
    logic [DATA_W-1:0]        m_data;
    logic                     m_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    // Transmitter side: takes the datapath push, drives the consumer side.
    modport master (
        input  in_valid, in_data, m_ready,
        output in_ready, m_valid, m_data, count, overflow
    );

    // Environment side: datapath producer plus downstream consumer.
    modport slave (
        output in_valid, in_data, m_ready,
        input  in_ready, m_valid, m_data, count, overflow
    );
endinterface

// File: rtl/fpadd_result_tx.sv
// Buffers adder results in a DEPTH-entry first-word-fall-through queue toward a valid/ready consumer.
// Latency: 1 cycle from push to head visibility; 1 word/cycle sustained while partially filled.
// Backpressure: in_ready drops when full; words offered while full are dropped and latch overflow.
module fpadd_result_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    fpadd_result_tx_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              overflow;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    // Status comes straight from the state register, so no input reaches the outputs combinationally.
    assign full  = (state == ST_FULL);
    assign empty = (state == ST_EMPTY);

    // A full buffer refuses the word even if the head is leaving this cycle.
    assign push = bus.in_valid && !full;
    assign drop = bus.in_valid && full;
    assign pop  = !empty && bus.m_ready;

    // Occupancy bookkeeping and buffer-state decode for the next cycle.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
        if (count_nxt == '0) begin
            state_nxt = ST_EMPTY;
        end else if (count_nxt == CW'(DEPTH)) begin
            state_nxt = ST_FULL;
        end else begin
            state_nxt = ST_PARTIAL;
        end
    end

    // State, occupancy, pointers and the sticky drop flag; reset discards all held words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready = !full;
    assign bus.m_valid  = !empty;
    assign bus.m_data   = empty ? '0 : mem[rd_ptr];
    assign bus.count    = count;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_fpadd_result_tx.sv
module tb_fpadd_result_tx;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic reset;

    fpadd_result_tx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fpadd_result_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of held words plus the sticky drop flag.
    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        mr;
        logic        e_mv;
        logic [31:0] e_md;
        int          e_cnt;
        logic        e_rdy;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] exp_md;
        exp_md = (model_q.size() != 0) ? model_q[0] : 32'h0;
        chk({tag, ".m_valid"},  {31'd0, bus.m_valid},  {31'd0, model_q.size() != 0});
        chk({tag, ".m_data"},   bus.m_data,            exp_md);
        chk({tag, ".count"},    {29'd0, bus.count},    model_q.size());
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, model_q.size() < DEPTH});
        chk({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, model_ovf});
    endtask

    // One clock: drive inputs, step the model across the edge, compare at the falling edge.
    task automatic cycle(input logic rst, input logic iv, input logic [31:0] id,
                         input logic mr, input string tag);
        bit do_pop, do_push, do_drop;
        reset        = rst;
        bus.in_valid = iv;
        bus.in_data  = id;
        bus.m_ready  = mr;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            do_pop  = (model_q.size() != 0) && mr;
            do_push = iv && (model_q.size() < DEPTH);
            do_drop = iv && (model_q.size() >= DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(id);
            if (do_drop) model_ovf = 1'b1;
        end
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic add_vec(input logic iv, input logic [31:0] id, input logic mr,
                           input logic e_mv, input logic [31:0] e_md, input int e_cnt,
                           input logic e_rdy, input logic e_ovf);
        vec_t v;
        v.iv = iv; v.id = id; v.mr = mr;
        v.e_mv = e_mv; v.e_md = e_md; v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    initial begin
        model_ovf    = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b0;

        // Directed table: single word with stall, then fill, overflow, full-with-pop drop, drain.
        add_vec(1, 32'h3F800000, 0, 1, 32'h3F800000, 1, 1, 0);
        add_vec(0, 32'h0,        0, 1, 32'h3F800000, 1, 1, 0);
        add_vec(0, 32'h0,        0, 1, 32'h3F800000, 1, 1, 0);
        add_vec(0, 32'h0,        0, 1, 32'h3F800000, 1, 1, 0);
        add_vec(0, 32'h0,        1, 0, 32'h0,        0, 1, 0);
        add_vec(1, 32'h1,        0, 1, 32'h1,        1, 1, 0);
        add_vec(1, 32'h2,        0, 1, 32'h1,        2, 1, 0);
        add_vec(1, 32'h3,        0, 1, 32'h1,        3, 1, 0);
        add_vec(1, 32'h4,        0, 1, 32'h1,        4, 0, 0);
        add_vec(1, 32'h5,        0, 1, 32'h1,        4, 0, 1);
        add_vec(1, 32'h6,        1, 1, 32'h2,        3, 1, 1);
        add_vec(0, 32'h0,        1, 1, 32'h3,        2, 1, 1);
        add_vec(0, 32'h0,        1, 1, 32'h4,        1, 1, 1);
        add_vec(0, 32'h0,        1, 0, 32'h0,        0, 1, 1);

        // Reset then idle.
        cycle(1, 0, 0, 0, "rst");
        cycle(1, 0, 0, 0, "rst");
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, "idle");
            chk("idle.m_valid",  {31'd0, bus.m_valid},  32'd0);
            chk("idle.m_data",   bus.m_data,            32'd0);
            chk("idle.count",    {29'd0, bus.count},    32'd0);
            chk("idle.in_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("idle.overflow", {31'd0, bus.overflow}, 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(0, vecs[i].iv, vecs[i].id, vecs[i].mr, "vec");
            chk($sformatf("vec%0d.m_valid", i),  {31'd0, bus.m_valid},  {31'd0, vecs[i].e_mv});
            chk($sformatf("vec%0d.m_data", i),   bus.m_data,            vecs[i].e_md);
            chk($sformatf("vec%0d.count", i),    {29'd0, bus.count},    vecs[i].e_cnt);
            chk($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d.overflow", i), {31'd0, bus.overflow}, {31'd0, vecs[i].e_ovf});
        end

        // Streaming: one word in and one out every cycle, occupancy pinned at 1.
        cycle(1, 0, 0, 0, "rst");
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 32'h100 + i, 1, "stream");
            chk("stream.m_data", bus.m_data,         32'h100 + i);
            chk("stream.count",  {29'd0, bus.count}, 32'd1);
        end
        cycle(0, 0, 0, 1, "stream_end");
        chk("stream_end.m_valid", {31'd0, bus.m_valid}, 32'd0);

        // Wrap-around: six pushes with random consumer readiness, then drain.
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 32'h200 + i, 1'($urandom_range(0, 1)), "wrap");
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 1, "wrap_drain");
        end

        // Reset mid-operation with count=3 and overflow set.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 32'h300 + i, 0, "pre_rst");
        end
        cycle(0, 0, 0, 1, "pre_rst");
        chk("pre_rst.count",    {29'd0, bus.count},    32'd3);
        chk("pre_rst.overflow", {31'd0, bus.overflow}, 32'd1);
        cycle(1, 1, 32'hDEAD, 1, "mid_rst");
        chk("mid_rst.count",    {29'd0, bus.count},    32'd0);
        chk("mid_rst.m_valid",  {31'd0, bus.m_valid},  32'd0);
        chk("mid_rst.overflow", {31'd0, bus.overflow}, 32'd0);
        chk("mid_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        cycle(0, 1, 32'hA, 0, "post_rst");
        chk("post_rst.m_data",  bus.m_data,            32'hA);

        // Randomized traffic against the queue model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom,
                  ($urandom_range(0, 9) < 5),
                  "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpadd_result_tx.md
# fpadd_result_tx

Output-side transmitter for the floating-point adder peripheral. It accepts one 32-bit result per cycle from the adder datapath (a push-only interface) and delivers the results to the downstream consumer over a valid/ready handshake. A DEPTH-entry first-word-fall-through buffer absorbs consumer stalls. A sticky overflow flag records any result lost while the buffer was full.

## Interface
- DATA_W, 32: result word width.
- DEPTH, 4: buffer entries; power of two, minimum 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- in_valid  input  1  datapath presents a result on in_data this cycle.
- in_data  input  DATA_W  result word.
- in_ready  output  1  buffer can accept a word; equals !full.
- m_valid  output  1  head word is available on m_data.
- m_data  output  DATA_W  head word; 0 when m_valid=0.
- m_ready  input  1  consumer accepts the head word this cycle.
- count  output  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- overflow  output  1  sticky; a word was offered while full and dropped.

## Operation
- Storage: DEPTH×DATA_W array, wr_ptr and rd_ptr of $clog2(DEPTH) bits, and count.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- push = in_valid && in_ready. On push, mem[wr_ptr] <= in_data and wr_ptr advances.
- pop = m_valid && m_ready. On pop, rd_ptr advances.
- count updates as +1 on push only, -1 on pop only, and is unchanged on push and pop together.
- m_valid = !empty. m_data = mem[rd_ptr] when m_valid, else 0.
- in_ready = !full, independent of m_ready. A full buffer accepts no word in the same cycle it pops; there is no pass-through when full.
- in_valid && !in_ready drops the word and sets overflow <= 1. overflow stays set until reset.
- No bypass when empty: a word pushed into an empty buffer is not visible in that same cycle.
- Word order is strictly FIFO. No word is duplicated or skipped.
- Buffer states:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- State transitions follow the count rules above. Push and pop together leave the state unchanged.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0, overflow=0.
  - Hence m_valid=0, m_data=0, in_ready=1.
  - Array contents are don't-care.
- Reset mid-operation: all held words are discarded. The cycle after reset deasserts, m_valid=0 and in_ready=1. A push or pop coinciding with reset is ignored.

## Timing
- Latency from input to output is 1 cycle. A word pushed at edge N gives m_valid=1 with that word on m_data after edge N, if it is the head.
- Throughput is 1 word/cycle sustained while 0<count<DEPTH and m_ready=1.
- While m_valid=1 && m_ready=0, m_data and m_valid hold stable.
- m_valid, in_ready, count and overflow are functions of registers only. There is no combinational path from in_valid or m_ready to any output. m_data depends only on registers and the array.
- count, in_ready and overflow reflect a push, pop or drop on the cycle after the edge on which it occurred.

## Test plan
- Reset then idle: after reset, count=0, m_valid=0, m_data=0, in_ready=1, overflow=0 for 5 cycles.
- Single word: push 0x3F800000 with m_ready=0. Next cycle m_valid=1, m_data=0x3F800000, count=1. It holds for 3 cycles. Raise m_ready: one pop, then m_valid=0.
- Fill and overflow, DEPTH=4, m_ready=0: push 0x1, 0x2, 0x3, 0x4, then in_ready=0 and count=4. Push 0x5: dropped, overflow=1. Drain: outputs 0x1..0x4 in order, and overflow stays 1.
- Streaming: m_ready=1 with in_valid=1 for 20 cycles carrying 0x100..0x113. Output is the same sequence, 1 cycle delayed, with count constant at 1 and no gaps.
- Wrap-around and simultaneous push/pop: push 6 words with a random m_ready pattern. Output order is correct across the pointer wrap. Cycles with both push and pop leave count unchanged.
- Reset mid-operation: with count=3, assert reset for 1 cycle while in_valid=1 and m_ready=1. Afterwards count=0, m_valid=0, overflow=0, and the next push of 0xA is the next output.
